// File: rtl/result_acc_pkg.sv
// result_accumulator shared types and constants.
// Sizes, FSM states and the window payload bundle.
package result_acc_pkg;

  localparam int RA_DATA_W = 4;
  localparam int RA_WINDOW = 4;

  function automatic int sum_w(input int data_w,
                               input int window);
    return data_w + $clog2(window);
  endfunction

  localparam int RA_SUM_W = sum_w(RA_DATA_W, RA_WINDOW);
  localparam int RA_CNT_W = $clog2(RA_WINDOW + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACCUM,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [RA_SUM_W-1:0]  sum;
    logic [RA_DATA_W-1:0] max;
    logic [RA_CNT_W-1:0]  count;
  } window_t;

endpackage

// File: rtl/result_out_slot.sv
// One-deep valid/ready holding register for a window payload.
// Ports: load_i/data_i fill, out_ready_i drains, valid_o/data_o/free_o.
module result_out_slot
  import result_acc_pkg::*;
#(
  parameter type T = window_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  T     data_i,
  input  logic out_ready_i,
  output logic valid_o,
  output T     data_o,
  output logic free_o
);

  logic valid_q, valid_d;
  T     data_q, data_d;

  // A load in the same edge as a drain keeps the slot full.
  always_comb begin
    valid_d = load_i | (valid_q & ~out_ready_i);
    data_d  = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = ~valid_q | out_ready_i;

endmodule

// File: rtl/result_accumulator.sv
// Windowed sum/max/count of a sample stream with flush.
// Ports: in_valid/in_data/in_ready, flush, out_* valid/ready window.
module result_accumulator
  import result_acc_pkg::*;
#(
  parameter  int DATA_W = RA_DATA_W,
  parameter  int WINDOW = RA_WINDOW,
  localparam int SUM_W  = sum_w(DATA_W, WINDOW),
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count
);

  logic [SUM_W-1:0]  acc_q, acc_d, acc_nx;
  logic [DATA_W-1:0] max_q, max_d, max_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;

  logic    slot_free, slot_load;
  window_t slot_din, slot_dout;
  logic    flush_pend, last, accept;

  assign flush_pend = (state_q == ST_FLUSH);
  assign last       = (cnt_q == CNT_W'(WINDOW - 1));

  // Only the window-completing sample waits on a blocked slot.
  assign in_ready = ~flush_pend & ~(~slot_free & last);
  assign accept   = in_valid & in_ready;

  assign acc_nx = acc_q + SUM_W'(in_data);
  assign max_nx = (in_data > max_q) ? in_data : max_q;

  always_comb begin
    acc_d     = acc_q;
    max_d     = max_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    slot_load = 1'b0;
    slot_din  = '0;
    unique case (state_q)
      ST_FLUSH: begin
        if (slot_free) begin
          if (cnt_q != '0) begin
            slot_load      = 1'b1;
            slot_din.sum   = acc_q;
            slot_din.max   = max_q;
            slot_din.count = cnt_q;
          end
          acc_d   = '0;
          max_d   = '0;
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end
      end
      ST_EMPTY, ST_ACCUM: begin
        if (accept) begin
          if (last) begin
            slot_load      = 1'b1;
            slot_din.sum   = acc_nx;
            slot_din.max   = max_nx;
            slot_din.count = CNT_W'(WINDOW);
            acc_d          = '0;
            max_d          = '0;
            cnt_d          = '0;
          end else begin
            acc_d = acc_nx;
            max_d = max_nx;
            cnt_d = cnt_q + 1'b1;
          end
        end
        // The sample of this cycle is already folded in above.
        if (flush) begin
          state_d = ST_FLUSH;
        end else if (cnt_d == '0) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      acc_q   <= acc_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  result_out_slot #(
    .T(window_t)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (slot_load),
    .data_i     (slot_din),
    .out_ready_i(out_ready),
    .valid_o    (out_valid),
    .data_o     (slot_dout),
    .free_o     (slot_free)
  );

  assign out_sum   = slot_dout.sum;
  assign out_max   = slot_dout.max;
  assign out_count = slot_dout.count;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator.
// Per-cycle vector table plus an async-reset sequence.
module tb_result_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic [3:0] out_max;
  logic [2:0] out_count;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  result_accumulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_max  (out_max),
    .out_count(out_count)
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       fl;
    logic       ordy;
    logic       xrdy;
    logic       xov;
    int         xsum;
    int         xmax;
    int         xcnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic v, input int d,
                              input logic fl, input logic ordy,
                              input logic xrdy, input logic xov,
                              input int xs, input int xm,
                              input int xc);
    vec_t t;
    t.v = v; t.d = 4'(d); t.fl = fl; t.ordy = ordy;
    t.xrdy = xrdy; t.xov = xov;
    t.xsum = xs; t.xmax = xm; t.xcnt = xc;
    return t;
  endfunction

  task automatic chk(input string name, input int act,
                     input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic xov,
                         input int xs, input int xm,
                         input int xc);
    chk({tag, ".out_valid"}, int'(out_valid), int'(xov));
    if (xov) begin
      chk({tag, ".out_sum"}, int'(out_sum), xs);
      chk({tag, ".out_max"}, int'(out_max), xm);
      chk({tag, ".out_count"}, int'(out_count), xc);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    in_valid  = t.v;
    in_data   = t.d;
    flush     = t.fl;
    out_ready = t.ordy;
    #1;
    chk({tag, ".in_ready"}, int'(in_ready), int'(t.xrdy));
    @(posedge clk);
    #1;
    chk_out(tag, t.xov, t.xsum, t.xmax, t.xcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    flush = 1'b0; out_ready = 1'b1;

    // full window
    vt.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 5, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 15, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 0, 1, 1, 1, 24, 15, 4));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush partial
    vt.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 7, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 9, 7, 2));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush with empty window
    vt.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush with sample, partial
    vt.push_back(mk(1, 4, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 6, 1, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 10, 6, 2));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // flush with window-completing sample
    vt.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 3, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 4, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 1, 1, 1, 1, 10, 4, 4));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
    // backpressure, eight 15s
    vt.push_back(mk(1, 15, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 15, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 15, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 15, 0, 0, 1, 1, 60, 15, 4));
    vt.push_back(mk(1, 15, 0, 0, 1, 1, 60, 15, 4));
    vt.push_back(mk(1, 15, 0, 0, 1, 1, 60, 15, 4));
    vt.push_back(mk(1, 15, 0, 0, 1, 1, 60, 15, 4));
    vt.push_back(mk(1, 15, 0, 0, 0, 1, 60, 15, 4));
    vt.push_back(mk(1, 15, 0, 1, 1, 1, 60, 15, 4));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_sum", int'(out_sum), 0);
    chk("rst.out_max", int'(out_max), 0);
    chk("rst.out_count", int'(out_count), 0);
    chk("rst.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i], $sformatf("v%0d", i));
    end

    // hold a window, start another, then reset mid-window
    step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "ar0");
    step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "ar1");
    step(mk(1, 1, 0, 0, 1, 0, 0, 0, 0), "ar2");
    step(mk(1, 1, 0, 0, 1, 1, 4, 1, 4), "ar3");
    step(mk(1, 2, 0, 0, 1, 1, 4, 1, 4), "ar4");
    step(mk(1, 3, 0, 0, 1, 1, 4, 1, 4), "ar5");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", int'(out_valid), 0);
    chk("ar.out_sum", int'(out_sum), 0);
    chk("ar.in_ready", int'(in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(1, 1, 0, 1, 1, 0, 0, 0, 0), "ar6");
    step(mk(1, 1, 0, 1, 1, 0, 0, 0, 0), "ar7");
    step(mk(1, 1, 0, 1, 1, 0, 0, 0, 0), "ar8");
    step(mk(1, 1, 0, 1, 1, 1, 4, 1, 4), "ar9");
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0), "ar10");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
